// File: rtl/pipeline_if_id_pkg.sv
// Shared fetch/decode definitions: widths, bubble encoding, PC increment, fetch FSM states.
package pipeline_if_id_pkg;

    localparam int unsigned IF_ADDR_W  = 32;
    localparam int unsigned IF_INSTR_W = 32;
    localparam int unsigned IF_CNT_W   = 32;

    localparam logic [IF_INSTR_W-1:0] IF_NOP_INSTR = 32'h0000_0000;
    localparam logic [IF_ADDR_W-1:0]  IF_PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [IF_INSTR_W-1:0] instr;
        logic [IF_ADDR_W-1:0]  pc4;
    } if_id_entry_t;

endpackage

// File: rtl/if_hold_buf.sv
// Single-entry instr/pc4 register with load/clear; parks a response while decode is frozen.
module if_hold_buf #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc4_in,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc4
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc4_q, pc4_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (clear) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
        end else if (load) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign instr = instr_q;
    assign pc4   = pc4_q;

endmodule

// File: rtl/pipeline_if_id.sv
// Instruction fetch (one outstanding request) and IF/ID register with decode-freeze hold buffer.
// Optional stall counter enabled by `define FETCH_STALL_CNT_EN.
module pipeline_if_id
    import pipeline_if_id_pkg::*;
#(
    parameter int unsigned        ADDR_W    = IF_ADDR_W,
    parameter int unsigned        INSTR_W   = IF_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR,
    parameter logic [ADDR_W-1:0]  PC_INC    = IF_PC_INC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   pc_in,
    output logic                PC_Freeze,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                ID_Freeze,
    input  logic                IF_Flush,
    output logic                if_id_valid,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc4,
    output logic [IF_CNT_W-1:0] fetch_stall_cnt
);

    fetch_state_e       state_q, state_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]  if_id_pc4_q, if_id_pc4_d;

    logic               retire;
    logic               buf_load, buf_clear;
    logic [ADDR_W-1:0]  pc4_next;
    logic [INSTR_W-1:0] buf_instr;
    logic [ADDR_W-1:0]  buf_pc4;

    assign pc4_next = pc_in + PC_INC;

    if_hold_buf #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_hold_buf (
        .clk      (clk),
        .rst_n    (reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (imem_rsp_data),
        .pc4_in   (pc4_next),
        .instr    (buf_instr),
        .pc4      (buf_pc4)
    );

    // Next state, retire detection and IF/ID update; flush outranks everything.
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;

        case (state_q)
            ST_REQ: begin
                if (!IF_Flush && imem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (IF_Flush) begin
                    state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    if (!ID_Freeze) begin
                        retire  = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (IF_Flush) begin
                    buf_clear = 1'b1;
                    state_d   = ST_REQ;
                end else if (!ID_Freeze) begin
                    retire    = 1'b1;
                    buf_clear = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The abandoned response is the only thing that can end a drain.
                if (imem_rsp_valid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase

        if (IF_Flush) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (retire) begin
            if_id_valid_d = 1'b1;
            if (state_q == ST_HOLD) begin
                if_id_instr_d = buf_instr;
                if_id_pc4_d   = buf_pc4;
            end else begin
                if_id_instr_d = imem_rsp_data;
                if_id_pc4_d   = pc4_next;
            end
        end else if (!ID_Freeze) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_REQ;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= '0;
        end else begin
            state_q       <= state_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
        end
    end

    assign imem_req_valid = (state_q == ST_REQ) && !IF_Flush;
    assign imem_addr      = pc_in;
    assign PC_Freeze      = !(retire || IF_Flush);
    assign if_id_valid    = if_id_valid_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc4      = if_id_pc4_q;

`ifdef FETCH_STALL_CNT_EN
    logic [IF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (PC_Freeze && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + IF_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign fetch_stall_cnt = stall_cnt_q;
`else
    assign fetch_stall_cnt = '0;
`endif

endmodule

// File: doc/pipeline_if_id.md
Name: pipeline_if_id

Overview:
- Instruction-fetch stage and IF/ID pipeline register, directly downstream of the PC register.
- Takes the current PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Captures the response into the IF/ID register, together with PC+4, for the decode stage.
- Drives PC_Freeze back to the PC register so the PC advances only when a fetch retires, or on a branch redirect.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- INSTR_W, 32, instruction width.
- NOP_INSTR, 32'h00000000, bubble instruction (sll $0,$0,0).
- PC_INC, 4, byte increment used for if_id_pc4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- pc_in  in  ADDR_W  current PC from the PC register.
- PC_Freeze  out  1  1 = PC register holds its value.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  ADDR_W  fetch address; equals pc_in.
- imem_rsp_valid  in  1  response valid.
- imem_rsp_data  in  INSTR_W  fetched instruction.
- ID_Freeze  in  1  decode stall from the hazard unit.
- IF_Flush  in  1  branch/jump taken; squash the fetch path.
- if_id_valid  out  1  IF/ID entry valid.
- if_id_instr  out  INSTR_W  IF/ID instruction.
- if_id_pc4  out  ADDR_W  IF/ID PC+PC_INC.
- fetch_stall_cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=REQ.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc4=0.
  - Hold buffer cleared; fetch_stall_cnt=0.
- States: REQ, WAIT, HOLD, DRAIN. At most one outstanding request.
- imem_req_valid = (state==REQ) && !IF_Flush. imem_addr = pc_in at all times.
- REQ:
  - valid&&ready moves to WAIT.
  - A request is never accepted in the cycle it is issued under a flush.
- WAIT, when imem_rsp_valid arrives:
  - If !ID_Freeze: load IF/ID (instr=rsp_data, pc4=pc_in+PC_INC mod 2^ADDR_W, valid=1) and go to REQ. This is the "retire" cycle.
  - If ID_Freeze: capture rsp_data and pc_in+PC_INC into the hold buffer and go to HOLD.
- HOLD: when !ID_Freeze, move the buffer into IF/ID (valid=1) and go to REQ. This is a retire cycle.
- PC_Freeze = !(retire || IF_Flush). The PC advances on exactly the edge where an instruction retires, so it is not advanced again until the next fetch retires. Minimum throughput: one instruction per 2 cycles (REQ, then WAIT with a 1-cycle response).
- IF/ID update when there is no retire and no flush:
  - ID_Freeze=1: hold all IF/ID outputs.
  - ID_Freeze=0: insert a bubble (valid=0, instr=NOP_INSTR, pc4 held).
- IF_Flush has priority over ID_Freeze and retire:
  - IF/ID becomes a bubble and PC_Freeze=0, so the PC loads the redirect target.
  - REQ: stay in REQ.
  - WAIT: go to DRAIN. If rsp_valid arrives in the same cycle, discard it and go to REQ.
  - HOLD: discard the buffer and go to REQ.
  - DRAIN: stay in DRAIN.
- DRAIN: PC_Freeze=1 unless IF_Flush. The next rsp_valid is discarded and the FSM goes to REQ.
- imem_rsp_valid in REQ or HOLD is a protocol error and is ignored. A response is never expected in its acceptance cycle.
- Reset mid-transaction abandons the outstanding response. The memory is required to be reset with the same signal.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- Defined: fetch_stall_cnt increments on every clock with reset=1 and PC_Freeze=1, saturates at 32'hFFFFFFFF, and is cleared only by reset.
- Undefined: fetch_stall_cnt is tied to 0 and no counter logic is synthesised. The port exists in both builds.

Decomposition:
- Shared package holds:
  - state encoding (REQ=2'd0, WAIT=2'd1, HOLD=2'd2, DRAIN=2'd3);
  - NOP_INSTR and PC_INC defaults;
  - widths shared with the PC register and the ID stage.
- One natural sub-module: if_hold_buf. It is a 1-entry instr/pc4 register with load/clear, reused later for the ID/EX skid.

Test Plan:
- Reset low mid-WAIT, then release → all outputs at reset values; first imem_addr=0 with req_valid=1.
- pc_in=0x100, ready=1, response 1 cycle later with data 0x8C220004 → IF/ID valid=1, instr=0x8C220004, pc4=0x104; PC_Freeze=0 only in the retire cycle.
- Response arrives with ID_Freeze=1 for 3 cycles → HOLD, PC_Freeze=1 for those 3 cycles, IF/ID unchanged; the entry loads on the first cycle with ID_Freeze=0.
- IF_Flush during WAIT → bubble (valid=0, instr=0), PC_Freeze=0 for 1 cycle; the next response is discarded (DRAIN), then a request for the new pc_in is issued.
- IF_Flush and ID_Freeze together with HOLD full → buffer discarded, IF/ID becomes a bubble, state=REQ.
- With FETCH_STALL_CNT_EN: 5 waiting cycles → fetch_stall_cnt=5. Without the macro: the counter reads 0 throughout.
